// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//  - state_t     : controller state encoding (IDLE/SCAN/DONE)
//  - cmp_flags_t : registered {g, l, e} result bundle
//  - DEF_WIDTH   : default operand width
package cmp_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic g;
      logic l;
      logic e;
   } cmp_flags_t;

endpackage : cmp_pkg

// File: rtl/cmp_bit_cell.sv
// Purely combinational 1-bit magnitude compare cell.
//  a, b  : input bits
//  gt_c  : a > b
//  lt_c  : a < b
//  eq_c  : a == b
module cmp_bit_cell (
   input  logic a,
   input  logic b,
   output logic gt_c,
   output logic lt_c,
   output logic eq_c
);

   assign gt_c = a & ~b;
   assign lt_c = ~a & b;
   assign eq_c = ~(a ^ b);

endmodule : cmp_bit_cell

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator, MSB first, with early exit on the
// first differing bit. A single shared 1-bit cell does all the comparing.
//  clk, rst_n   : clock, asynchronous active-low reset
//  start_in     : request, accepted in IDLE or DONE
//  a_in, b_in   : operands, captured with an accepted request
//  busy         : high while scanning
//  done         : one-cycle pulse, result flags valid
//  g_t/l_t/e_t  : held result flags (A>B, A<B, A==B)
module serial_mag_compare_ctrl
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             g_t,
   output logic             l_t,
   output logic             e_t
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] sh_a, sh_a_next;
   logic [WIDTH-1:0] sh_b, sh_b_next;
   logic [CNT_W-1:0] idx, idx_next;
   cmp_flags_t       flags, flags_next;
   logic             busy_next, done_next;
   logic             cell_gt, cell_lt, cell_eq;

   // Shared compare cell always looks at the current MSBs
   cmp_bit_cell u_cell (
      .a    (sh_a[WIDTH-1]),
      .b    (sh_b[WIDTH-1]),
      .gt_c (cell_gt),
      .lt_c (cell_lt),
      .eq_c (cell_eq)
   );

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sh_a  <= '0;
         sh_b  <= '0;
         idx   <= '0;
         flags <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         sh_a  <= sh_a_next;
         sh_b  <= sh_b_next;
         idx   <= idx_next;
         flags <= flags_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_next = state;
      sh_a_next  = sh_a;
      sh_b_next  = sh_b;
      idx_next   = idx;
      flags_next = flags;
      busy_next  = 1'b0;
      done_next  = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new request directly so back-to-back starts lose no cycle
            if (start_in) begin
               sh_a_next  = a_in;
               sh_b_next  = b_in;
               idx_next   = CNT_W'(WIDTH - 1);
               state_next = ST_SCAN;
               busy_next  = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end

         ST_SCAN: begin
            if (!cell_eq) begin
               flags_next = '{g: cell_gt, l: cell_lt, e: 1'b0};
               state_next = ST_DONE;
               done_next  = 1'b1;
            end else if (idx == '0) begin
               flags_next = '{g: 1'b0, l: 1'b0, e: 1'b1};
               state_next = ST_DONE;
               done_next  = 1'b1;
            end else begin
               sh_a_next = {sh_a[WIDTH-2:0], 1'b0};
               sh_b_next = {sh_b[WIDTH-2:0], 1'b0};
               idx_next  = idx - CNT_W'(1);
               busy_next = 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign g_t = flags.g;
   assign l_t = flags.l;
   assign e_t = flags.e;

endmodule : serial_mag_compare_ctrl

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl (WIDTH=8).
module tb_serial_mag_compare_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             g_t;
   logic             l_t;
   logic             e_t;

   int total = 0;
   int bad   = 0;

   // reference copy of the held result flags
   logic mg, ml, me;

   serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_in (start_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .g_t      (g_t),
      .l_t      (l_t),
      .e_t      (e_t)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Idle cycles: no busy, no done, flags held
   task automatic idle_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_ctl"}, 8'({busy, done}), 8'b00);
         chk({tag, "_flags"}, 8'({g_t, l_t, e_t}), 8'({mg, ml, me}));
      end
   endtask

   // Caller has driven start_in=1 with operands a/b at a negedge.
   // Returns at the negedge of the DONE cycle, after checking it.
   task automatic check_cmp(input logic [7:0] a, input logic [7:0] b,
                            input bit hold, input int pulse_at, input string tag);
      int  k;
      bit  found;
      logic eg, el, ee;
      k     = WIDTH;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && (a[i] != b[i])) begin
            k     = WIDTH - i;
            found = 1'b1;
         end
      end
      eg = (a > b);
      el = (a < b);
      ee = (a == b);
      @(posedge clk);
      for (int j = 0; j < k; j++) begin
         @(negedge clk);
         if (!hold) start_in = (j == pulse_at);
         // operand changes after capture must not matter
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         chk({tag, "_scan_ctl"}, 8'({busy, done}), 8'b10);
         chk({tag, "_scan_hold"}, 8'({g_t, l_t, e_t}), 8'({mg, ml, me}));
      end
      @(negedge clk);
      mg = eg;
      ml = el;
      me = ee;
      chk({tag, "_done_ctl"}, 8'({busy, done}), 8'b01);
      chk({tag, "_result"}, 8'({g_t, l_t, e_t}), 8'({mg, ml, me}));
   endtask

   initial begin
      logic [7:0] ra, rb;
      int         sel;
      mg = 1'b0; ml = 1'b0; me = 1'b0;

      // 1. reset with random inputs
      rst_n    = 1'b0;
      start_in = 1'b1;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         chk("reset", 8'({busy, done, g_t, l_t, e_t}), 8'h00);
      end
      rst_n    = 1'b1;
      start_in = 1'b0;
      idle_check(3, "post_reset");

      // 2. MSB differs
      start_in = 1'b1; a_in = 8'h80; b_in = 8'h7F;
      check_cmp(8'h80, 8'h7F, 1'b0, -1, "msb");
      start_in = 1'b0;
      idle_check(2, "msb_idle");

      // 3. LSB differs, stray start pulse mid-scan
      start_in = 1'b1; a_in = 8'h10; b_in = 8'h11;
      check_cmp(8'h10, 8'h11, 1'b0, 3, "lsb");
      start_in = 1'b0;
      idle_check(2, "lsb_idle");

      // 4. equal, then long hold
      start_in = 1'b1; a_in = 8'hA5; b_in = 8'hA5;
      check_cmp(8'hA5, 8'hA5, 1'b0, -1, "eq");
      start_in = 1'b0;
      idle_check(20, "eq_hold");

      // 5. back-to-back with start held high
      start_in = 1'b1; a_in = 8'h03; b_in = 8'h01;
      check_cmp(8'h03, 8'h01, 1'b1, -1, "b2b1");
      a_in = 8'h00; b_in = 8'hFF;
      check_cmp(8'h00, 8'hFF, 1'b1, -1, "b2b2");
      start_in = 1'b0;
      idle_check(2, "b2b_idle");

      // 6. reset in the middle of a scan
      start_in = 1'b1; a_in = 8'h01; b_in = 8'h00;
      @(posedge clk);
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_busy", 8'(busy), 8'h01);
      #2 rst_n = 1'b0;
      #1 chk("midrst_async", 8'({busy, done, g_t, l_t, e_t}), 8'h00);
      mg = 1'b0; ml = 1'b0; me = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_check(2, "midrst_idle");
      start_in = 1'b1; a_in = 8'h01; b_in = 8'h00;
      check_cmp(8'h01, 8'h00, 1'b0, -1, "after_rst");
      start_in = 1'b0;
      idle_check(1, "after_rst_idle");

      // randomized compares, optional back-to-back chaining
      for (int n = 0; n < 40; n++) begin
         ra  = 8'($urandom);
         sel = int'($urandom_range(0, 3));
         if (sel == 0)      rb = ra;
         else if (sel == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
         else               rb = 8'($urandom);
         start_in = 1'b1; a_in = ra; b_in = rb;
         check_cmp(ra, rb, 1'($urandom), int'($urandom_range(0, 9)), "rand");
         if ($urandom_range(0, 1) == 0) begin
            start_in = 1'b0;
            idle_check(int'($urandom_range(1, 3)), "rand_idle");
         end
      end
      start_in = 1'b0;
      idle_check(2, "final_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_mag_compare_ctrl
